ex_mem_pipe_reg: RTL and testbench

Parametrised EX/MEM pipeline register for the MIPS datapath. It sits between the execute stage (ALU, branch-target adder) and the memory stage. It carries the memory, branch and write-back control bundle plus the ALU result, zero flag, store data and destination register. Compared with the fixed 16-bit latch it adds:

- a valid/ready handshake with a 2-entry skid buffer, so a stall does not lose data;
- a flush that inserts bubbles;
- side-effect gating of control outputs;
- a registered PC-source decision;
- a saturating stall counter.

---
 rtl/ex_mem_pipe_reg.sv | 130 +++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a two-slot skid buffer, flush bubbles, gated side-effect
// controls, a PC-source decision and a saturating stall counter. State moves on the falling edge.
module ex_mem_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_MemRead,
    input  logic              in_MemWrite,
    input  logic              in_Branch,
    input  logic              in_MemtoReg,
    input  logic              in_RegWrite,
    input  logic [DATA_W-1:0] in_BranchTarget,
    input  logic [DATA_W-1:0] in_ALUResult,
    input  logic              in_Zero,
    input  logic [DATA_W-1:0] in_ReadData_2,
    input  logic [REG_W-1:0]  in_WriteRegister,
    input  logic              out_ready,
    output logic              O_Valid,
    output logic              O_MemRead,
    output logic              O_MemWrite,
    output logic              O_Branch,
    output logic              O_MemtoReg,
    output logic              O_RegWrite,
    output logic [DATA_W-1:0] O_BranchTarget,
    output logic [DATA_W-1:0] O_ALUResult,
    output logic              O_Zero,
    output logic [DATA_W-1:0] O_Write_Data,
    output logic [REG_W-1:0]  O_WriteRegister,
    output logic              O_PCSrc,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              mem_to_reg;
        logic              reg_write;
        logic [DATA_W-1:0] branch_target;
        logic [DATA_W-1:0] alu_result;
        logic              zero;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
    } entry_t;

    entry_t            in_entry;
    entry_t            main_q;
    entry_t            skid_q;
    logic              main_valid;
    logic              skid_valid;
    logic [CNT_W-1:0]  stall_q;
    logic              accept;
    logic              drain;
    logic              stalled;

    assign in_entry = '{
        mem_read:      in_MemRead,
        mem_write:     in_MemWrite,
        branch:        in_Branch,
        mem_to_reg:    in_MemtoReg,
        reg_write:     in_RegWrite,
        branch_target: in_BranchTarget,
        alu_result:    in_ALUResult,
        zero:          in_Zero,
        write_data:    in_ReadData_2,
        write_reg:     in_WriteRegister
    };

    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = !main_valid | out_ready;
    assign stalled  = main_valid & !out_ready;

    // Skid entry is always older than a new input, so it wins the main slot when draining.
    always_ff @(negedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            stall_q    <= '0;
        end else begin
            if (stalled && !flush && stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};

            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (drain) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= accept;
                    if (accept)
                        skid_q <= in_entry;
                end else if (accept) begin
                    main_q     <= in_entry;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end
    end

    // Side-effect controls are masked by valid; data fields keep their last loaded value.
    assign O_Valid         = main_valid;
    assign O_MemRead       = main_valid & main_q.mem_read;
    assign O_MemWrite      = main_valid & main_q.mem_write;
    assign O_Branch        = main_valid & main_q.branch;
    assign O_RegWrite      = main_valid & main_q.reg_write;
    assign O_MemtoReg      = main_q.mem_to_reg;
    assign O_BranchTarget  = main_q.branch_target;
    assign O_ALUResult     = main_q.alu_result;
    assign O_Zero          = main_q.zero;
    assign O_Write_Data    = main_q.write_data;
    assign O_WriteRegister = main_q.write_reg;
    assign O_PCSrc         = main_valid & main_q.branch & main_q.zero;
    assign stall_count     = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: streaming, backpressure, branch decision, flush,
// counter saturation (second instance with a 4-bit counter) and reset during a stall.
module tb_ex_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite, in_Zero;
    logic [15:0] in_BranchTarget, in_ALUResult, in_ReadData_2;
    logic [2:0]  in_WriteRegister;

    logic        in_ready, O_Valid, O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite;
    logic        O_Zero, O_PCSrc;
    logic [15:0] O_BranchTarget, O_ALUResult, O_Write_Data, stall_count;
    logic [2:0]  O_WriteRegister;

    logic        s_in_ready, s_valid, s_mem_read, s_mem_write, s_branch, s_mem_to_reg;
    logic        s_reg_write, s_zero, s_pc_src;
    logic [15:0] s_branch_target, s_alu_result, s_write_data;
    logic [2:0]  s_write_reg;
    logic [3:0]  s_stall_count;

    int compare_count  = 0;
    int mismatch_count = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.DATA_W(16), .REG_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_Branch(in_Branch),
        .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite), .in_BranchTarget(in_BranchTarget),
        .in_ALUResult(in_ALUResult), .in_Zero(in_Zero), .in_ReadData_2(in_ReadData_2),
        .in_WriteRegister(in_WriteRegister), .out_ready(out_ready), .O_Valid(O_Valid),
        .O_MemRead(O_MemRead), .O_MemWrite(O_MemWrite), .O_Branch(O_Branch),
        .O_MemtoReg(O_MemtoReg), .O_RegWrite(O_RegWrite), .O_BranchTarget(O_BranchTarget),
        .O_ALUResult(O_ALUResult), .O_Zero(O_Zero), .O_Write_Data(O_Write_Data),
        .O_WriteRegister(O_WriteRegister), .O_PCSrc(O_PCSrc), .stall_count(stall_count)
    );

    ex_mem_pipe_reg #(.DATA_W(16), .REG_W(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_Branch(in_Branch),
        .in_MemtoReg(in_MemtoReg), .in_RegWrite(in_RegWrite), .in_BranchTarget(in_BranchTarget),
        .in_ALUResult(in_ALUResult), .in_Zero(in_Zero), .in_ReadData_2(in_ReadData_2),
        .in_WriteRegister(in_WriteRegister), .out_ready(out_ready), .O_Valid(s_valid),
        .O_MemRead(s_mem_read), .O_MemWrite(s_mem_write), .O_Branch(s_branch),
        .O_MemtoReg(s_mem_to_reg), .O_RegWrite(s_reg_write), .O_BranchTarget(s_branch_target),
        .O_ALUResult(s_alu_result), .O_Zero(s_zero), .O_Write_Data(s_write_data),
        .O_WriteRegister(s_write_reg), .O_PCSrc(s_pc_src), .stall_count(s_stall_count)
    );

    // Advance past one active (falling) edge and settle before sampling.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [15:0] alu,
                                  input logic mem_write, input logic reg_write,
                                  input logic branch, input logic zero,
                                  input logic [15:0] target, input logic [2:0] wreg);
        in_valid         = valid;
        in_ALUResult     = alu;
        in_MemWrite      = mem_write;
        in_RegWrite      = reg_write;
        in_Branch        = branch;
        in_Zero          = zero;
        in_BranchTarget  = target;
        in_WriteRegister = wreg;
        in_ReadData_2    = ~alu;
        in_MemRead       = reg_write;
        in_MemtoReg      = mem_write;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            mismatch_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        tick();
        rst = 1'b0;
        check_output("reset_valid", O_Valid, 0);
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_stall", stall_count, 0);
        check_output("reset_alu", O_ALUResult, 0);
        check_output("reset_pcsrc", O_PCSrc, 0);

        // Streaming with no backpressure.
        out_ready = 1'b1;
        apply_stimulus(1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd1);
        tick();
        check_output("stream0_valid", O_Valid, 1);
        check_output("stream0_alu", O_ALUResult, 16'h0011);
        check_output("stream0_regwrite", O_RegWrite, 1);
        check_output("stream0_wdata", O_Write_Data, 16'hFFEE);
        apply_stimulus(1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd2);
        tick();
        check_output("stream1_valid", O_Valid, 1);
        check_output("stream1_alu", O_ALUResult, 16'h0022);
        apply_stimulus(1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd3);
        tick();
        check_output("stream2_valid", O_Valid, 1);
        check_output("stream2_alu", O_ALUResult, 16'h0033);
        check_output("stream2_wreg", O_WriteRegister, 3);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        tick();
        check_output("stream_end_valid", O_Valid, 0);
        check_output("stream_end_regwrite", O_RegWrite, 0);
        check_output("stream_end_hold", O_ALUResult, 16'h0033);

        // Backpressure: A to main, B to skid, C refused until release.
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        apply_stimulus(1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd1);
        tick();
        check_output("bp_a_alu", O_ALUResult, 16'h1111);
        check_output("bp_a_stall", stall_count, 0);
        check_output("bp_a_ready", in_ready, 1);
        apply_stimulus(1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd2);
        tick();
        check_output("bp_b_ready", in_ready, 0);
        check_output("bp_b_stall", stall_count, 1);
        apply_stimulus(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd3);
        tick();
        tick();
        check_output("bp_c_main", O_ALUResult, 16'h1111);
        check_output("bp_c_ready", in_ready, 0);
        check_output("bp_c_stall", stall_count, 3);
        out_ready = 1'b1;
        tick();
        check_output("bp_rel_b", O_ALUResult, 16'h2222);
        check_output("bp_rel_ready", in_ready, 1);
        check_output("bp_rel_stall", stall_count, 3);
        tick();
        check_output("bp_rel_c", O_ALUResult, 16'h3333);
        check_output("bp_rel_c_valid", O_Valid, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        tick();
        check_output("bp_drained", O_Valid, 0);

        // Branch decision.
        apply_stimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 3'd0);
        tick();
        check_output("br_taken_pcsrc", O_PCSrc, 1);
        check_output("br_taken_target", O_BranchTarget, 16'h0040);
        check_output("br_taken_branch", O_Branch, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        tick();
        check_output("br_after_pcsrc", O_PCSrc, 0);
        check_output("br_after_branch", O_Branch, 0);
        check_output("br_after_target", O_BranchTarget, 16'h0040);
        apply_stimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0080, 3'd0);
        tick();
        check_output("br_nz_pcsrc", O_PCSrc, 0);
        check_output("br_nz_branch", O_Branch, 1);

        // Flush with both slots full and a new input present.
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        apply_stimulus(1'b1, 16'h4444, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 3'd5);
        tick();
        check_output("fl_d_memwrite", O_MemWrite, 1);
        apply_stimulus(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 3'd6);
        tick();
        check_output("fl_e_ready", in_ready, 0);
        flush = 1'b1;
        apply_stimulus(1'b1, 16'h6666, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 3'd7);
        tick();
        flush = 1'b0;
        check_output("fl_valid", O_Valid, 0);
        check_output("fl_memwrite", O_MemWrite, 0);
        check_output("fl_regwrite", O_RegWrite, 0);
        check_output("fl_ready", in_ready, 1);
        check_output("fl_alu_kept", O_ALUResult, 16'h4444);
        check_output("fl_wreg_kept", O_WriteRegister, 5);
        check_output("fl_stall", stall_count, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        out_ready = 1'b1;
        tick();
        check_output("fl_skid_gone", O_Valid, 0);

        // Counter saturation on the 4-bit instance.
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        apply_stimulus(1'b1, 16'h0AAA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        tick();
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        for (int i = 0; i < 14; i++) tick();
        check_output("sat_14", s_stall_count, 14);
        for (int i = 0; i < 6; i++) tick();
        check_output("sat_15", s_stall_count, 15);
        check_output("wide_20", stall_count, 20);
        rst = 1'b1; tick(); rst = 1'b0;
        check_output("sat_reset", s_stall_count, 0);

        // Reset in the middle of a stall with a store held.
        out_ready = 1'b0;
        apply_stimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0123, 3'd4);
        tick();
        tick();
        check_output("rs_memwrite", O_MemWrite, 1);
        check_output("rs_stall", stall_count, 1);
        check_output("rs_memtoreg", O_MemtoReg, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rs_valid", O_Valid, 0);
        check_output("rs_memwrite0", O_MemWrite, 0);
        check_output("rs_memtoreg0", O_MemtoReg, 0);
        check_output("rs_alu0", O_ALUResult, 0);
        check_output("rs_target0", O_BranchTarget, 0);
        check_output("rs_wreg0", O_WriteRegister, 0);
        check_output("rs_stall0", stall_count, 0);
        check_output("rs_ready", in_ready, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        out_ready = 1'b1;
        tick();
        check_output("rs_skid_gone", O_Valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
